// File: rtl/event_encoder_8to3.sv
// rtl/event_encoder_8to3.sv - 8-line event capture with priority-ordered 3-bit index hand-off
module event_encoder_8to3 #(
  parameter int LOW_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic       EN,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] pend_cnt,
  output logic       ovf,
  input  logic       ovf_clr
);

  logic [7:0] pend;
  logic [7:0] cap_mask;
  logic [7:0] clr_mask;
  logic [7:0] pend_next;
  logic       lost;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  assign cap_mask  = in & {8{EN}};
  assign out_valid = |pend;

  // Priority encoder over the registered pending set; the last match in scan order wins.
  always_comb begin
    out = 3'd0;
    if (LOW_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend[i]) out = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) out = 3'(i);
      end
    end
  end

  // Retire the presented event on acceptance; a fresh capture on the same line survives.
  always_comb begin
    clr_mask  = (out_valid && out_ready) ? (8'b0000_0001 << out) : 8'b0000_0000;
    pend_next = (pend & ~clr_mask) | cap_mask;
    lost      = |(cap_mask & pend & ~clr_mask);
  end

  // Pending set and its population count move together so pend_cnt never lags pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 8'd0;
      pend_cnt <= 4'd0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= popcount8(pend_next);
    end
  end

  // Sticky loss flag; a new loss in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (lost) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// tb/tb_event_encoder_8to3.sv - scoreboard bench for both service orders against a set-based model
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in;
  logic       en;
  logic       out_ready;
  logic       ovf_clr;

  logic [2:0] out0, out1;
  logic       vld0, vld1;
  logic [3:0] cnt0, cnt1;
  logic       ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int out;
    int valid;
    int cnt;
    int ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // model: per DUT, a list of which lines are pending plus the sticky flag
  bit mp[2][8];
  bit movf[2];

  always #5 clk = ~clk;

  event_encoder_8to3 #(.LOW_FIRST(1)) dut_low (
    .clk(clk), .rst_n(rst_n), .in(in), .EN(en), .out(out0), .out_valid(vld0),
    .out_ready(out_ready), .pend_cnt(cnt0), .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  event_encoder_8to3 #(.LOW_FIRST(0)) dut_high (
    .clk(clk), .rst_n(rst_n), .in(in), .EN(en), .out(out1), .out_valid(vld1),
    .out_ready(out_ready), .pend_cnt(cnt1), .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // index of the next event to serve, or -1 when nothing is pending
  function automatic int model_pick(input int d);
    if (d == 0) begin
      for (int i = 0; i < 8; i++) if (mp[d][i]) return i;
    end else begin
      for (int i = 7; i >= 0; i--) if (mp[d][i]) return i;
    end
    return -1;
  endfunction

  function automatic exp_t model_view(input int d);
    exp_t e;
    int p;
    p = model_pick(d);
    e.valid = (p >= 0) ? 1 : 0;
    e.out   = (p >= 0) ? p : 0;
    e.cnt   = 0;
    for (int i = 0; i < 8; i++) e.cnt += mp[d][i] ? 1 : 0;
    e.ovf   = movf[d] ? 1 : 0;
    return e;
  endfunction

  task automatic model_step(input int d, input logic [7:0] vin, input logic ven,
                            input logic rdy, input logic oclr);
    int taken;
    bit lost;
    taken = rdy ? model_pick(d) : -1;
    lost  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ven && vin[i]) begin
        if (mp[d][i] && i != taken) lost = 1'b1;
        mp[d][i] = 1'b1;
      end else if (i == taken) begin
        mp[d][i] = 1'b0;
      end
    end
    if (lost) movf[d] = 1'b1;
    else if (oclr) movf[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mp[d][i] = 1'b0;
      movf[d] = 1'b0;
    end
  endtask

  // one clock of stimulus; expectations for the state after the edge are queued first
  task automatic cycle(input logic [7:0] vin, input logic ven, input logic rdy, input logic oclr);
    @(negedge clk);
    in = vin; en = ven; out_ready = rdy; ovf_clr = oclr;
    model_step(0, vin, ven, rdy, oclr);
    model_step(1, vin, ven, rdy, oclr);
    q0.push_back(model_view(0));
    q1.push_back(model_view(1));
    @(posedge clk);
  endtask

  // monitor: after every edge out of reset, pop one expectation per DUT and compare
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("low.out_valid", int'(vld0), e.valid);
        chk("low.out", int'(out0), e.out);
        chk("low.pend_cnt", int'(cnt0), e.cnt);
        chk("low.ovf", int'(ovf0), e.ovf);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("high.out_valid", int'(vld1), e.valid);
        chk("high.out", int'(out1), e.out);
        chk("high.pend_cnt", int'(cnt1), e.cnt);
        chk("high.ovf", int'(ovf1), e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in = 8'h00; en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #23;
    chk("reset.out_valid", int'(vld0 | vld1), 0);
    chk("reset.out", int'(out0) + int'(out1), 0);
    chk("reset.pend_cnt", int'(cnt0) + int'(cnt1), 0);
    chk("reset.ovf", int'(ovf0 | ovf1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single event on line 5, then accept it
    cycle(8'h20, 1, 0, 0);
    #2;
    chk("single.out", int'(out0), 5);
    chk("single.valid", int'(vld0), 1);
    chk("single.cnt", int'(cnt0), 1);
    cycle(8'h00, 1, 1, 0);
    #2;
    chk("single.drained", int'(vld0), 0);

    // multi-hot capture served in priority order; ready while idle does nothing
    cycle(8'h89, 1, 1, 0);
    #2;
    chk("multi.low_first", int'(out0), 0);
    chk("multi.high_first", int'(out1), 7);
    chk("multi.cnt", int'(cnt0), 3);
    repeat (3) cycle(8'h00, 1, 1, 0);

    // enable gating
    repeat (2) cycle(8'hFF, 0, 0, 0);
    #2;
    chk("gate.cnt", int'(cnt0), 0);

    // overflow, clear, set-wins on retire, set-wins on clear
    cycle(8'h04, 1, 0, 0);
    cycle(8'h04, 1, 0, 0);
    #2;
    chk("ovf.set", int'(ovf0), 1);
    chk("ovf.cnt", int'(cnt0), 1);
    cycle(8'h00, 0, 0, 1);
    cycle(8'h04, 1, 1, 0);
    #2;
    chk("setwins.ovf", int'(ovf0), 0);
    chk("setwins.cnt", int'(cnt0), 1);
    cycle(8'h04, 1, 0, 1);
    #2;
    chk("ovf.set_over_clr", int'(ovf0), 1);
    cycle(8'h00, 0, 1, 1);

    // full register and counter ceiling
    cycle(8'hFF, 1, 0, 0);
    #2;
    chk("full.cnt", int'(cnt0), 8);
    cycle(8'hFF, 1, 0, 0);
    #2;
    chk("full.cnt_hold", int'(cnt1), 8);
    chk("full.ovf", int'(ovf1), 1);
    repeat (9) cycle(8'h00, 0, 1, 1);

    // randomized traffic, sparse strobes
    for (int n = 0; n < 400; n++) begin
      cycle(8'($urandom & $urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 15) == 0));
    end

    // asynchronous reset between edges with five events pending
    repeat (10) cycle(8'h00, 0, 1, 1);
    cycle(8'h1F, 1, 0, 0);
    #2;
    chk("areset.pre_cnt", int'(cnt0), 5);
    #1;
    rst_n = 1'b0;
    in = 8'h00; en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #1;
    chk("areset.valid", int'(vld0 | vld1), 0);
    chk("areset.out", int'(out0) + int'(out1), 0);
    chk("areset.cnt", int'(cnt0) + int'(cnt1), 0);
    chk("areset.ovf", int'(ovf0 | ovf1), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h02, 1, 0, 0);
    #2;
    chk("areset.recapture", int'(out0), 1);
    cycle(8'h00, 0, 1, 0);
    #3;
    chk("queue.drained", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_encoder_8to3.md
EVENT_ENCODER_8TO3 -- requirements
Module: event_encoder_8to3

Interface
REQ-001 Parameter: LOW_FIRST, default 1, selects service order: 1 = lowest pending index first, 0 = highest pending index first.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port: in  input  8  one-hot or multi-hot event strobes; bit i = event on line i.
REQ-005 Port: EN  input  1  capture enable; events are ignored while low.
REQ-006 Port: out  output  3  binary index of the event currently presented.
REQ-007 Port: out_valid  output  1  high while at least one event is pending.
REQ-008 Port: out_ready  input  1  consumer accepts the presented event when high with out_valid.
REQ-009 Port: pend_cnt  output  4  number of pending events, 0..8.
REQ-010 Port: ovf  output  1  sticky flag: an event was lost to an already-pending line.
REQ-011 Port: ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-012 Block SHALL hold an 8-bit pending register pend; capture mask each cycle = in AND {8{EN}}.
REQ-013 On each rising edge: pend_next = (pend AND NOT clr_mask) OR capture mask; clr_mask = one-hot of out when out_valid AND out_ready, else 0.
REQ-014 Simultaneous capture and clear on the same bit SHALL leave that bit set (set wins); event is not lost and ovf is not raised.
REQ-015 out_valid SHALL equal OR of pend; out and out_valid are combinational from registered pend only (no combinational path from in, EN or out_ready).
REQ-016 Latency: an event captured at edge N SHALL be visible on out_valid/out after edge N; minimum in-to-out latency 1 cycle.
REQ-017 With LOW_FIRST=1, out SHALL be the index of the lowest set bit of pend; with LOW_FIRST=0, the highest set bit.
REQ-018 When pend is 0, out SHALL be 3'b000 and out_valid 0.
REQ-019 out SHALL hold stable while out_valid=1 and out_ready=0, unless a higher-priority event is captured (priority preemption permitted; consumer samples only on acceptance).
REQ-020 Exactly one event SHALL be retired per accepting cycle; a multi-hot capture is retired over successive accepts in priority order.
REQ-021 pend_cnt SHALL be a registered population count of pend_next, always equal to popcount(pend) after each edge; range 0..8, never wraps.
REQ-022 ovf SHALL set at an edge where any capture-mask bit i has pend[i]=1 and bit i is not being cleared in that cycle.
REQ-023 ovf_clr SHALL clear ovf at the edge; if a set condition coincides with ovf_clr, set wins.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 While rst_n=0, regardless of clk: pend=0, pend_cnt=0, ovf=0, hence out=0, out_valid=0.
REQ-026 Reset asserted mid-operation SHALL discard all pending events immediately; the first edge after rst_n deassertion captures normally.

Verification
REQ-027 Single event: EN=1, in=8'b0010_0000 for one cycle, out_ready=0 -> next cycle out=5, out_valid=1, pend_cnt=1; then out_ready=1 for one cycle -> out_valid=0, pend_cnt=0.
REQ-028 Multi-hot ordering: in=8'b1000_1001 one cycle, out_ready held 1, LOW_FIRST=1 -> out sequence 0,3,7 on three consecutive cycles, pend_cnt 3,2,1, then out_valid=0; with LOW_FIRST=0 -> 7,3,0.
REQ-029 Enable gating: EN=0, in=8'hFF -> out_valid stays 0, pend_cnt=0, ovf=0.
REQ-030 Overflow and set-wins: pend bit 2 set, out_ready=0, in=8'b0000_0100 -> ovf=1, pend_cnt unchanged; repeat with out_ready=1 presenting out=2 -> bit 2 remains pending, ovf not newly set; ovf_clr=1 alone -> ovf=0.
REQ-031 Full and counter bound: in=8'hFF, out_ready=0 -> pend_cnt=8, out_valid=1; in=8'hFF again -> ovf=1, pend_cnt stays 8.
REQ-032 Async reset: with pend_cnt=5, drop rst_n between clock edges -> out_valid=0, out=0, pend_cnt=0, ovf=0 before next edge.
